// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// fetch_queue: FIFO of fetched instruction packets between fetch and decode.
// A flush discards every entry; an empty queue presents a NOP bubble to decode.
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [WIDTH-1:0]       enq_pc,
  input  logic [WIDTH-1:0]       enq_inst,
  input  logic [WIDTH-1:0]       enq_normal,
  input  logic                   enq_bp_en,
  input  logic                   enq_bp_decision,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [WIDTH-1:0]       deq_pc,
  output logic [WIDTH-1:0]       deq_inst,
  output logic [WIDTH-1:0]       deq_normal,
  output logic                   deq_bp_en,
  output logic                   deq_bp_decision,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] normal;
    logic             bp_en;
    logic             bp_decision;
  } pkt_t;

  pkt_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_fire, deq_fire, wr_en;
  pkt_t             enq_pkt, head;

  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  assign wr_en     = enq_fire && !flush;

  assign enq_pkt = '{pc: enq_pc, inst: enq_inst, normal: enq_normal,
                     bp_en: enq_bp_en, bp_decision: enq_bp_decision};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq_fire && !deq_fire)      count_d = count_q + CNT_W'(1);
      else if (deq_fire && !enq_fire) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds whole packets and is deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= enq_pkt;
  end

  always_comb begin
    head      = '0;
    head.inst = NOP_INST;
    if (count_q != '0) head = mem_q[rd_ptr_q];
  end

  assign deq_pc          = head.pc;
  assign deq_inst        = head.inst;
  assign deq_normal      = head.normal;
  assign deq_bp_en       = head.bp_en;
  assign deq_bp_decision = head.bp_decision;
  assign count           = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
// tb_fetch_queue: table vectors, directed corner sequences and a randomized run
// compared against a queue-based packet model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid, enq_ready;
  logic [31:0] enq_pc, enq_inst, enq_normal;
  logic        enq_bp_en, enq_bp_decision;
  logic        deq_valid, deq_ready;
  logic [31:0] deq_pc, deq_inst, deq_normal;
  logic        deq_bp_en, deq_bp_decision;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_normal(enq_normal),
    .enq_bp_en(enq_bp_en), .enq_bp_decision(enq_bp_decision),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_normal(deq_normal),
    .deq_bp_en(deq_bp_en), .deq_bp_decision(deq_bp_decision),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] normal;
    logic        bp_en;
    logic        bp_dec;
  } pkt_t;

  pkt_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic [31:0] inst,
                       input logic bpe, input logic bpd, input logic dr, input logic fl);
    enq_valid       = ev;
    enq_pc          = pc;
    enq_inst        = inst;
    enq_normal      = pc + 32'd4;
    enq_bp_en       = bpe;
    enq_bp_decision = bpd;
    deq_ready       = dr;
    flush           = fl;
  endtask

  task automatic check_model();
    pkt_t e;
    e      = '0;
    e.inst = NOP;
    if (mq.size() > 0) e = mq[0];
    chk("m_count",     64'(count),           64'(mq.size()));
    chk("m_deq_valid", 64'(deq_valid),       64'(mq.size() != 0));
    chk("m_enq_ready", 64'(enq_ready),       64'(mq.size() != DEPTH));
    chk("m_pc",        64'(deq_pc),          64'(e.pc));
    chk("m_inst",      64'(deq_inst),        64'(e.inst));
    chk("m_normal",    64'(deq_normal),      64'(e.normal));
    chk("m_bp_en",     64'(deq_bp_en),       64'(e.bp_en));
    chk("m_bp_dec",    64'(deq_bp_decision), 64'(e.bp_dec));
  endtask

  task automatic model_update();
    bit do_enq, do_deq;
    if (!rst || flush) begin
      mq.delete();
    end else begin
      do_enq = enq_valid && (mq.size() < DEPTH);
      do_deq = deq_ready && (mq.size() > 0);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back('{enq_pc, enq_inst, enq_normal, enq_bp_en, enq_bp_decision});
    end
  endtask

  // Inputs are set at posedge+1; outputs depend only on state, so they are stable here.
  task automatic tick();
    check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic ev; logic [31:0] pc; logic [31:0] inst; logic bpe; logic bpd; logic dr; logic fl;
    int e_count; logic e_valid; logic e_rdy; logic [31:0] e_pc; logic [31:0] e_inst;
    logic e_bpe; logic e_bpd;
  } vec_t;

  vec_t vt[9];

  initial begin
    int   sent;
    logic [31:0] got[$];

    vt[0] = '{1, 32'h0,  32'h11, 1, 1, 0, 0, 1, 1, 1, 32'h0, 32'h11, 1, 1};
    vt[1] = '{1, 32'h4,  32'h22, 1, 0, 0, 0, 2, 1, 1, 32'h0, 32'h11, 1, 1};
    vt[2] = '{1, 32'h8,  32'h33, 0, 0, 0, 0, 3, 1, 1, 32'h0, 32'h11, 1, 1};
    vt[3] = '{1, 32'hC,  32'h44, 0, 1, 0, 0, 4, 1, 0, 32'h0, 32'h11, 1, 1};
    vt[4] = '{1, 32'h10, 32'h55, 1, 1, 0, 0, 4, 1, 0, 32'h0, 32'h11, 1, 1};
    vt[5] = '{1, 32'h10, 32'h55, 1, 1, 1, 0, 3, 1, 1, 32'h4, 32'h22, 1, 0};
    vt[6] = '{0, 32'h0,  32'h0,  0, 0, 1, 0, 2, 1, 1, 32'h8, 32'h33, 0, 0};
    vt[7] = '{0, 32'h0,  32'h0,  0, 0, 1, 0, 1, 1, 1, 32'hC, 32'h44, 0, 1};
    vt[8] = '{0, 32'h0,  32'h0,  0, 0, 1, 0, 0, 0, 1, 32'h0, NOP,    0, 0};

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_inst",      64'(deq_inst),  64'(NOP));
    chk("rst_pc",        64'(deq_pc),    64'd0);
    chk("rst_normal",    64'(deq_normal), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: fill, reject when full, drain, predictor fields.
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].ev, vt[i].pc, vt[i].inst, vt[i].bpe, vt[i].bpd, vt[i].dr, vt[i].fl);
      tick();
      chk($sformatf("v%0d_count", i), 64'(count),           64'(vt[i].e_count));
      chk($sformatf("v%0d_valid", i), 64'(deq_valid),       64'(vt[i].e_valid));
      chk($sformatf("v%0d_rdy", i),   64'(enq_ready),       64'(vt[i].e_rdy));
      chk($sformatf("v%0d_pc", i),    64'(deq_pc),          64'(vt[i].e_pc));
      chk($sformatf("v%0d_inst", i),  64'(deq_inst),        64'(vt[i].e_inst));
      chk($sformatf("v%0d_bpe", i),   64'(deq_bp_en),       64'(vt[i].e_bpe));
      chk($sformatf("v%0d_bpd", i),   64'(deq_bp_decision), 64'(vt[i].e_bpd));
    end

    // Asynchronous reset mid-cycle with three entries held.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h40 + 32'(4 * k), 32'h70 + 32'(k), 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    chk("arst_count",     64'(count),     64'd0);
    chk("arst_deq_valid", 64'(deq_valid), 64'd0);
    chk("arst_enq_ready", 64'(enq_ready), 64'd1);
    chk("arst_inst",      64'(deq_inst),  64'(NOP));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Ordering across pointer wrap with deq_ready toggling 1,0,1,...
    sent = 0;
    for (int c = 0; c < 100 && got.size() < 10; c++) begin
      drive(sent < 10, 32'h100 + 32'(4 * sent), 32'hA000_0000 + 32'(sent), 0, 0, (c % 2) == 0, 0);
      if (deq_valid && deq_ready) begin
        got.push_back(deq_pc);
        chk("order_normal", 64'(deq_normal), 64'(deq_pc + 32'd4));
      end
      if (enq_valid && enq_ready) sent++;
      tick();
    end
    chk("order_len", 64'(got.size()), 64'd10);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("order_pc%0d", k), 64'(got[k]), 64'(32'h100 + 32'(4 * k)));
    drive(0, 0, 0, 0, 0, 1, 0);
    while (count != 0) tick();

    // Simultaneous enqueue and dequeue at occupancy 2.
    drive(1, 32'h400, 32'h1, 0, 0, 0, 0); tick();
    drive(1, 32'h404, 32'h2, 0, 0, 0, 0); tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1, 32'h404 + 32'(4 * k), 32'h2 + 32'(k), 0, 0, 1, 0);
      tick();
      chk("both_count", 64'(count),  64'd2);
      chk("both_head",  64'(deq_pc), 64'(32'h400 + 32'(4 * k)));
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    while (count != 0) tick();

    // Flush beats same-cycle enqueue and dequeue.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h500 + 32'(4 * k), 32'h9, 1, 1, 0, 0);
      tick();
    end
    drive(1, 32'h200, 32'hDEAD, 1, 1, 1, 1);
    tick();
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_valid", 64'(deq_valid), 64'd0);
    chk("flush_rdy",   64'(enq_ready), 64'd1);
    chk("flush_inst",  64'(deq_inst),  64'(NOP));
    drive(1, 32'h300, 32'hBEEF, 0, 1, 0, 0);
    tick();
    chk("post_flush_pc",    64'(deq_pc),   64'h300);
    chk("post_flush_inst",  64'(deq_inst), 64'hBEEF);
    chk("post_flush_count", 64'(count),    64'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();

    // Randomized traffic against the packet model.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
